fifo_drain_router: RTL

- Sits directly downstream of the fifo block; drains its read side and steers each popped entry to one of NUM_PORTS output ports.
- Output port is selected by the entry's dst field; each output port has a valid/ready handshake.
- Entries whose dst is out of range are dropped and counted.
- Single clock domain; asynchronous active-low reset.

---
 rtl/fifo_router_pkg.sv | 22 ++
 rtl/fifo_drain_router_sat_counter.sv | 22 ++
 rtl/fifo_drain_router.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fifo_router_pkg.sv
// Shared types and default widths for the fifo drain router.
package fifo_router_pkg;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_SRC_W     = 2;
  localparam int unsigned DEF_DST_W     = 2;
  localparam int unsigned DEF_NUM_PORTS = 4;
  localparam int unsigned DEF_CNT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_SRC_W-1:0]  src;
    logic [DEF_DST_W-1:0]  dst;
    logic [DEF_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/fifo_drain_router_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/fifo_drain_router.sv
// Drains the upstream fifo and steers each entry to the port named by its dst.
// Optional per-port forward counters and stats clear under `ROUTER_STATS_EN.
module fifo_drain_router #(
  parameter int unsigned DATA_W    = fifo_router_pkg::DEF_DATA_W,
  parameter int unsigned SRC_W     = fifo_router_pkg::DEF_SRC_W,
  parameter int unsigned DST_W     = fifo_router_pkg::DEF_DST_W,
  parameter int unsigned NUM_PORTS = fifo_router_pkg::DEF_NUM_PORTS,
  parameter int unsigned CNT_W     = fifo_router_pkg::DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       fifo_emptyp,
  output logic                       fifo_readp,
  input  logic [SRC_W-1:0]           fifo_src,
  input  logic [DST_W-1:0]           fifo_dst,
  input  logic [DATA_W-1:0]          fifo_data,
  output logic [NUM_PORTS-1:0]       out_valid,
  input  logic [NUM_PORTS-1:0]       out_ready,
  output logic [SRC_W-1:0]           out_src,
  output logic [DATA_W-1:0]          out_data,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       busy
`ifdef ROUTER_STATS_EN
  ,
  input  logic                       stats_clr,
  output logic [NUM_PORTS*CNT_W-1:0] fwd_cnt
`endif
);

  import fifo_router_pkg::*;

  localparam logic [1:0] IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] FETCH = 2'(ST_FETCH);
  localparam logic [1:0] SEND  = 2'(ST_SEND);

  logic [1:0]           state, state_nxt;
  logic [NUM_PORTS-1:0] valid_nxt;
  logic [SRC_W-1:0]     src_nxt;
  logic [DATA_W-1:0]    data_nxt;
  logic                 busy_nxt;
  logic                 drop_inc;
  logic                 hs;
  logic                 in_range;
  logic                 cnt_clr;

  assign hs       = |(out_valid & out_ready);
  assign in_range = 32'(fifo_dst) < NUM_PORTS;

  // State and registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      out_valid <= '0;
      out_src   <= '0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= valid_nxt;
      out_src   <= src_nxt;
      out_data  <= data_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next state, pop strobe and next output values
  always_comb begin
    state_nxt  = state;
    fifo_readp = 1'b0;
    valid_nxt  = out_valid;
    src_nxt    = out_src;
    data_nxt   = out_data;
    drop_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_emptyp) begin
          fifo_readp = 1'b1;
          state_nxt  = FETCH;
        end
      end
      FETCH: begin
        src_nxt  = fifo_src;
        data_nxt = fifo_data;
        if (in_range) begin
          valid_nxt = NUM_PORTS'(1) << fifo_dst;
          state_nxt = SEND;
        end else begin
          drop_inc = 1'b1;
          if (!fifo_emptyp) begin
            fifo_readp = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      SEND: begin
        // Only the addressed port's ready matters: out_valid is one-hot
        if (hs) begin
          valid_nxt = '0;
          if (!fifo_emptyp) begin
            fifo_readp = 1'b1;
            state_nxt  = FETCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = '0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

`ifdef ROUTER_STATS_EN
  assign cnt_clr = stats_clr;

  for (genvar i = 0; i < int'(NUM_PORTS); i++) begin : g_fwd
    sat_counter #(.W(CNT_W)) u_fwd_cnt (
      .clk  (clk),
      .rstn (rstn),
      .inc  (out_valid[i] & out_ready[i]),
      .clr  (cnt_clr),
      .cnt  (fwd_cnt[i*CNT_W +: CNT_W])
    );
  end
`else
  assign cnt_clr = 1'b0;
`endif

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk  (clk),
    .rstn (rstn),
    .inc  (drop_inc),
    .clr  (cnt_clr),
    .cnt  (drop_cnt)
  );

endmodule
